instr_mem_loadable: RTL and testbench

- Parametrised instruction memory for the single-cycle/multicycle CPU, replacing fixed hard-coded program words.
- Contents are written at run time through a byte-serial load port with valid/ready handshake.
- Fetch port is registered (1-cycle latency) with a valid flag and an out-of-range fault.
- Sits between the PC register and the decoder; the loader side connects to a UART/switch-bank byte source.

---
 rtl/instr_mem_loadable_pkg.sv | 18 +
 rtl/instr_mem_loadable_if.sv | 32 +++
 rtl/instr_mem_loadable_packer.sv | 49 ++++
 rtl/instr_mem_loadable.sv | 96 +++++++++
 tb/tb_instr_mem_loadable.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loadable_pkg.sv
// Shared types and constants for the run-time loadable instruction memory.
// The opcode/funct values are the encodings used to build test programs.
package instr_mem_pkg;

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

  localparam int          BYTE_W   = 8;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Fetch and byte-serial load signals of the instruction memory.
// The CPU/loader side is the master; the memory is the slave.
interface instr_mem_loadable_if
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] RD;
  logic              rd_valid;
  logic              addr_fault;
  logic              load_start;
  logic [BYTE_W-1:0] load_byte;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W:0]   load_words;

  modport master (
    output fetch_en, address, load_start, load_byte, load_valid, load_last,
    input  RD, rd_valid, addr_fault, load_ready, load_busy, load_done, load_words
  );

  modport slave (
    input  fetch_en, address, load_start, load_byte, load_valid, load_last,
    output RD, rd_valid, addr_fault, load_ready, load_busy, load_done, load_words
  );
endinterface

// File: rtl/instr_mem_loadable_packer.sv
// Assembles MSB-first bytes into a DATA_W word; word_o already contains the
// byte being accepted so the memory can be written on that same edge.
module instr_mem_loadable_packer
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              accept_i,
  input  logic              last_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_stb_o
);
  localparam int BYTES = DATA_W / BYTE_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] asm_q;

  // Unfilled low slots of asm_q are always zero, which gives the padding.
  always_comb begin
    word_o = asm_q;
    word_o[DATA_W-1-BYTE_W*int'(cnt_q) -: BYTE_W] = byte_i;
  end

  assign word_stb_o = accept_i && (last_i || (cnt_q == CNT_W'(BYTES-1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i || word_stb_o) begin
      cnt_q <= '0;
    end else if (accept_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i || word_stb_o) begin
      asm_q <= '0;
    end else if (accept_i) begin
      asm_q <= word_o;
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory with registered fetch port and a byte-serial loader.
// Contents come only from the loader; reset clears everything to NOP.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_mem_loadable_if.slave  bus
);
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH-1);

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [DATA_W-1:0] rd_q;
  logic              rd_valid_q;
  logic              fault_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   wr_ptr_d;
  logic              load_ready;
  logic              accept;
  logic              clear;
  logic              word_stb;
  logic [DATA_W-1:0] word;

  assign load_ready = (state_q == LOAD) && (wr_ptr_q < DEPTH_C);
  assign accept     = bus.load_valid && load_ready;
  assign clear      = (state_q == RUN) && bus.load_start;
  assign wr_ptr_d   = wr_ptr_q + (ADDR_W+1)'(1);

  instr_mem_loadable_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .byte_i     (bus.load_byte),
    .accept_i   (accept),
    .last_i     (bus.load_last),
    .word_o     (word),
    .word_stb_o (word_stb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      rd_q       <= DATA_W'(NOP_WORD);
      rd_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < 2**IDX_W; i++) mem_q[i] <= DATA_W'(NOP_WORD);
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.fetch_en) begin
            rd_valid_q <= 1'b1;
            if ({1'b0, bus.address} < DEPTH_C) begin
              rd_q    <= mem_q[bus.address[IDX_W-1:0]];
              fault_q <= 1'b0;
            end else begin
              rd_q    <= DATA_W'(NOP_WORD);
              fault_q <= 1'b1;
            end
          end
          if (bus.load_start) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
          end
        end
        LOAD: begin
          // Filling the last word ends the session even without load_last.
          if (word_stb) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= word;
            wr_ptr_q <= wr_ptr_d;
            if (bus.load_last || (wr_ptr_q == LAST_PTR)) state_q <= FLUSH;
          end
        end
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.RD         = rd_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.addr_fault = fault_q;
  assign bus.load_ready = load_ready;
  assign bus.load_busy  = (state_q != RUN);
  assign bus.load_done  = (state_q == FLUSH);
  assign bus.load_words = wr_ptr_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench: a DEPTH=32 memory for fetch/load/reset scenarios and a
// DEPTH=4 memory for the overflow scenario.
module tb_instr_mem_loadable;

  logic clk = 1'b0;
  logic rst32;
  logic rst4;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done32 = 0;
  int   done4 = 0;
  int   accepted;

  always #5 clk = ~clk;

  instr_mem_loadable_if #(.ADDR_W(8), .DATA_W(32)) bus32 ();
  instr_mem_loadable_if #(.ADDR_W(8), .DATA_W(32)) bus4 ();

  instr_mem_loadable #(.ADDR_W(8), .DEPTH(32), .DATA_W(32)) u32 (
    .clk(clk), .reset(rst32), .bus(bus32)
  );
  instr_mem_loadable #(.ADDR_W(8), .DEPTH(4), .DATA_W(32)) u4 (
    .clk(clk), .reset(rst4), .bus(bus4)
  );

  always @(negedge clk) begin
    if (bus32.load_done) done32++;
    if (bus4.load_done)  done4++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch32(input logic [7:0] a, input logic [31:0] exp_rd, input logic exp_fault);
    bus32.fetch_en = 1'b1;
    bus32.address  = a;
    @(posedge clk); #1;
    bus32.fetch_en = 1'b0;
    check($sformatf("u32 rd_valid @%0d", a), bus32.rd_valid, 1'b1);
    check($sformatf("u32 RD @%0d", a), bus32.RD, exp_rd);
    check($sformatf("u32 fault @%0d", a), bus32.addr_fault, exp_fault);
  endtask

  task automatic fetch4(input logic [7:0] a, input logic [31:0] exp_rd, input logic exp_fault);
    bus4.fetch_en = 1'b1;
    bus4.address  = a;
    @(posedge clk); #1;
    bus4.fetch_en = 1'b0;
    check($sformatf("u4 rd_valid @%0d", a), bus4.rd_valid, 1'b1);
    check($sformatf("u4 RD @%0d", a), bus4.RD, exp_rd);
    check($sformatf("u4 fault @%0d", a), bus4.addr_fault, exp_fault);
  endtask

  task automatic send_byte32(input logic [7:0] b, input logic last);
    bus32.load_byte  = b;
    bus32.load_valid = 1'b1;
    bus32.load_last  = last;
    @(posedge clk); #1;
    bus32.load_valid = 1'b0;
    bus32.load_last  = 1'b0;
  endtask

  task automatic send_word32(input logic [31:0] w, input logic last);
    for (int k = 0; k < 4; k++) send_byte32(w[31-8*k -: 8], last && (k == 3));
  endtask

  task automatic start32();
    bus32.load_start = 1'b1;
    @(posedge clk); #1;
    bus32.load_start = 1'b0;
  endtask

  initial begin
    bus32.fetch_en = 0; bus32.address = '0; bus32.load_start = 0;
    bus32.load_byte = '0; bus32.load_valid = 0; bus32.load_last = 0;
    bus4.fetch_en = 0; bus4.address = '0; bus4.load_start = 0;
    bus4.load_byte = '0; bus4.load_valid = 0; bus4.load_last = 0;
    rst32 = 1'b1;
    rst4  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset RD", bus32.RD, 32'h0);
    check("reset rd_valid", bus32.rd_valid, 1'b0);
    check("reset fault", bus32.addr_fault, 1'b0);
    check("reset ready", bus32.load_ready, 1'b0);
    check("reset busy", bus32.load_busy, 1'b0);
    check("reset done", bus32.load_done, 1'b0);
    check("reset words", bus32.load_words, 9'd0);
    rst32 = 1'b0;
    rst4  = 1'b0;

    for (int a = 0; a < 4; a++) fetch32(8'(a), 32'h0, 1'b0);
    @(posedge clk); #1;
    check("idle rd_valid", bus32.rd_valid, 1'b0);

    // Seven-word program
    start32();
    check("s1 busy", bus32.load_busy, 1'b1);
    check("s1 ready", bus32.load_ready, 1'b1);
    check("s1 words start", bus32.load_words, 9'd0);
    send_word32(32'h2001_0003, 1'b0);
    send_word32(32'h2002_0009, 1'b0);
    send_word32(32'h0022_1020, 1'b0);
    send_word32(32'h0022_1824, 1'b0);
    send_word32(32'h0022_2025, 1'b0);
    send_word32(32'h0022_2827, 1'b0);
    check("s1 no early done", done32, 0);
    send_word32(32'h00A4_302A, 1'b1);
    check("s1 done pulse", bus32.load_done, 1'b1);
    check("s1 ready in flush", bus32.load_ready, 1'b0);
    check("s1 words", bus32.load_words, 9'd7);
    @(posedge clk); #1;
    check("s1 done cleared", bus32.load_done, 1'b0);
    check("s1 busy cleared", bus32.load_busy, 1'b0);
    check("s1 done count", done32, 1);
    fetch32(8'd0, 32'h2001_0003, 1'b0);
    fetch32(8'd1, 32'h2002_0009, 1'b0);
    fetch32(8'd2, 32'h0022_1020, 1'b0);
    fetch32(8'd3, 32'h0022_1824, 1'b0);
    fetch32(8'd4, 32'h0022_2025, 1'b0);
    fetch32(8'd5, 32'h0022_2827, 1'b0);
    fetch32(8'd6, 32'h00A4_302A, 1'b0);
    fetch32(8'd40, 32'h0, 1'b1);
    fetch32(8'd5, 32'h0022_2827, 1'b0);

    // Partial final word, plus a fetch attempted during LOAD
    start32();
    bus32.fetch_en = 1'b1;
    bus32.address  = 8'd0;
    @(posedge clk); #1;
    bus32.fetch_en = 1'b0;
    check("load fetch ignored", bus32.rd_valid, 1'b0);
    check("load RD holds", bus32.RD, 32'h0022_2827);
    send_byte32(8'hAA, 1'b0);
    send_byte32(8'hBB, 1'b0);
    send_byte32(8'hCC, 1'b0);
    send_byte32(8'hDD, 1'b0);
    send_byte32(8'h11, 1'b0);
    send_byte32(8'h22, 1'b1);
    check("s2 done pulse", bus32.load_done, 1'b1);
    check("s2 words", bus32.load_words, 9'd2);
    @(posedge clk); #1;
    check("s2 done count", done32, 2);
    fetch32(8'd0, 32'hAABB_CCDD, 1'b0);
    fetch32(8'd1, 32'h1122_0000, 1'b0);
    fetch32(8'd2, 32'h0022_1020, 1'b0);

    // DEPTH=4 overflow: only 16 of 20 bytes may be taken
    accepted = 0;
    bus4.load_start = 1'b1;
    @(posedge clk); #1;
    bus4.load_start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus4.load_ready) accepted++;
      bus4.load_byte  = 8'(8'h10 + i);
      bus4.load_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 16) check("u4 done after byte 16", bus4.load_done, 1'b1);
    end
    bus4.load_valid = 1'b0;
    check("u4 accepted bytes", accepted, 16);
    check("u4 words", bus4.load_words, 9'd4);
    check("u4 done count", done4, 1);
    check("u4 busy", bus4.load_busy, 1'b0);
    fetch4(8'd0, 32'h1112_1314, 1'b0);
    fetch4(8'd3, 32'h1D1E_1F20, 1'b0);
    fetch4(8'd4, 32'h0, 1'b1);

    // Reset in the middle of the third word
    start32();
    send_word32(32'hDEAD_BEEF, 1'b0);
    send_word32(32'h1234_5678, 1'b0);
    send_byte32(8'hAB, 1'b0);
    send_byte32(8'hCD, 1'b0);
    check("s3 words before reset", bus32.load_words, 9'd2);
    #2;
    rst32 = 1'b1;
    #1;
    check("mid reset busy", bus32.load_busy, 1'b0);
    check("mid reset RD", bus32.RD, 32'h0);
    check("mid reset words", bus32.load_words, 9'd0);
    check("mid reset ready", bus32.load_ready, 1'b0);
    @(posedge clk); #1;
    rst32 = 1'b0;
    @(posedge clk); #1;
    check("mid reset no done", done32, 2);
    fetch32(8'd0, 32'h0, 1'b0);
    fetch32(8'd1, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
